// File: rtl/arm7_pkg.sv
// Shared ARM7 core constants and the writeback sequencer state type.
package arm7_pkg;

  localparam logic [3:0] REG_PC        = 4'd15;
  localparam int         CPSR_NZCV_MSB = 31;
  localparam int         CPSR_NZCV_LSB = 28;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_LDM
  } wb_state_t;

endpackage

// File: rtl/wb_lowest_bit.sv
// 16-bit priority encoder: index of the lowest set bit, plus a found flag.
module wb_lowest_bit (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        found
);

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// ARM7 writeback stage: register file, PC and CPSR writes, plus LDM beat sequencing.
// Optional macro WB_BYPASS_EN adds a combinational forwarding copy of the port-1/PC write.
module writeback_unit
  import arm7_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_wen,
  input  logic [AW-1:0] ex_rd,
  input  logic [N-1:0]  ex_result,
  input  logic          ex_base_wen,
  input  logic [AW-1:0] ex_base_rd,
  input  logic [N-1:0]  ex_base_data,
  input  logic          ex_flags_wen,
  input  logic [3:0]    ex_flags,
  input  logic          ex_ldm,
  input  logic [15:0]   ex_reglist,
  input  logic [N-1:0]  cspr_cur,
  input  logic          mem_rvalid,
  input  logic [N-1:0]  mem_rdata,
  output logic          mem_rready,
  output logic [AW-1:0] write_address,
  output logic [N-1:0]  write_data,
  output logic          write_enable,
  output logic [AW-1:0] write_address2,
  output logic [N-1:0]  write_data2,
  output logic          write_enable2,
  output logic [N-1:0]  pc_update,
  output logic          pc_write,
  output logic [N-1:0]  cspr_update,
  output logic          cspr_write,
  output logic          busy
`ifdef WB_BYPASS_EN
  ,
  output logic          byp_valid,
  output logic [AW-1:0] byp_addr,
  output logic [N-1:0]  byp_data
`endif
);

  wb_state_t     state, state_nx;
  logic [15:0]   reglist, reglist_nx;
  logic [3:0]    low_idx;
  logic          low_found;
  logic          accept, ldm_beat;
  logic          res_wr, base_wr;

  logic          we1_nx, we2_nx, pcw_nx, cw_nx;
  logic [AW-1:0] a1_nx, a2_nx;
  logic [N-1:0]  d1_nx, d2_nx, pcu_nx, cu_nx;

  wb_lowest_bit u_lowest_bit (
    .vec   (reglist),
    .idx   (low_idx),
    .found (low_found)
  );

  assign accept   = ex_valid && ex_ready;
  assign ldm_beat = mem_rvalid && mem_rready && low_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WB_IDLE;
      reglist <= '0;
    end else begin
      state   <= state_nx;
      reglist <= reglist_nx;
    end
  end

  // Each beat retires the lowest pending register; the list empties on the final beat.
  always_comb begin
    state_nx   = state;
    reglist_nx = reglist;
    case (state)
      WB_IDLE: begin
        if (accept && ex_ldm) begin
          reglist_nx = ex_reglist;
          if (ex_reglist != '0) state_nx = WB_LDM;
        end
      end
      WB_LDM: begin
        if (ldm_beat) begin
          reglist_nx = reglist & (reglist - 16'd1);
          if (reglist_nx == '0) state_nx = WB_IDLE;
        end
      end
      default: state_nx = WB_IDLE;
    endcase
  end

  always_comb begin
    ex_ready   = 1'b0;
    mem_rready = 1'b0;
    busy       = 1'b0;
    case (state)
      WB_IDLE: ex_ready = rst_n;
      WB_LDM: begin
        mem_rready = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // The result write beats the base write when both name the same register (including R15).
  always_comb begin
    we1_nx = 1'b0;
    a1_nx  = '0;
    d1_nx  = '0;
    we2_nx = 1'b0;
    a2_nx  = '0;
    d2_nx  = '0;
    pcw_nx = 1'b0;
    pcu_nx = '0;
    cw_nx  = 1'b0;
    cu_nx  = '0;

    res_wr  = accept && !ex_ldm && ex_wen;
    base_wr = accept && ex_base_wen && !(res_wr && (ex_rd == ex_base_rd));

    if (res_wr) begin
      if (ex_rd == AW'(REG_PC)) begin
        pcw_nx = 1'b1;
        pcu_nx = ex_result;
      end else begin
        we1_nx = 1'b1;
        a1_nx  = ex_rd;
        d1_nx  = ex_result;
      end
    end

    if (base_wr) begin
      if (ex_base_rd == AW'(REG_PC)) begin
        pcw_nx = 1'b1;
        pcu_nx = ex_base_data;
      end else begin
        we2_nx = 1'b1;
        a2_nx  = ex_base_rd;
        d2_nx  = ex_base_data;
      end
    end

    if (accept && !ex_ldm && ex_flags_wen) begin
      cw_nx = 1'b1;
      cu_nx = cspr_cur;
      cu_nx[CPSR_NZCV_MSB:CPSR_NZCV_LSB] = ex_flags;
    end

    if (ldm_beat) begin
      if (low_idx == REG_PC) begin
        pcw_nx = 1'b1;
        pcu_nx = mem_rdata;
      end else begin
        we1_nx = 1'b1;
        a1_nx  = AW'(low_idx);
        d1_nx  = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable   <= 1'b0;
      write_address  <= '0;
      write_data     <= '0;
      write_enable2  <= 1'b0;
      write_address2 <= '0;
      write_data2    <= '0;
      pc_write       <= 1'b0;
      pc_update      <= '0;
      cspr_write     <= 1'b0;
      cspr_update    <= '0;
    end else begin
      write_enable   <= we1_nx;
      write_address  <= a1_nx;
      write_data     <= d1_nx;
      write_enable2  <= we2_nx;
      write_address2 <= a2_nx;
      write_data2    <= d2_nx;
      pc_write       <= pcw_nx;
      pc_update      <= pcu_nx;
      cspr_write     <= cw_nx;
      cspr_update    <= cu_nx;
    end
  end

`ifdef WB_BYPASS_EN
  // A single op can write port 1 and the PC together; port 1 takes the bypass then.
  assign byp_valid = we1_nx || pcw_nx;
  assign byp_addr  = we1_nx ? a1_nx : AW'(REG_PC);
  assign byp_data  = we1_nx ? d1_nx : pcu_nx;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, LDM sequences, reset and random ops.
module tb_writeback_unit;

  typedef struct packed {
    logic        wen;
    logic [3:0]  rd;
    logic [31:0] result;
    logic        base_wen;
    logic [3:0]  base_rd;
    logic [31:0] base_data;
    logic        flags_wen;
    logic [3:0]  flags;
    logic [31:0] cspr;
  } op_t;

  typedef struct packed {
    logic        we1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        we2;
    logic [3:0]  a2;
    logic [31:0] d2;
    logic        pcw;
    logic [31:0] pcu;
    logic        cw;
    logic [31:0] cu;
  } exp_t;

  typedef struct {
    string name;
    op_t   op;
    exp_t  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_wen, ex_base_wen, ex_flags_wen, ex_ldm;
  logic [3:0]  ex_rd, ex_base_rd, ex_flags;
  logic [31:0] ex_result, ex_base_data, cspr_cur;
  logic [15:0] ex_reglist;
  logic        mem_rvalid, mem_rready;
  logic [31:0] mem_rdata;
  logic [3:0]  write_address, write_address2;
  logic [31:0] write_data, write_data2, pc_update, cspr_update;
  logic        write_enable, write_enable2, pc_write, cspr_write, busy;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [3:0]  byp_addr;
  logic [31:0] byp_data;
`endif

  int errors = 0;
  int checks = 0;

  writeback_unit #(.N(32), .AW(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_wen         (ex_wen),
    .ex_rd          (ex_rd),
    .ex_result      (ex_result),
    .ex_base_wen    (ex_base_wen),
    .ex_base_rd     (ex_base_rd),
    .ex_base_data   (ex_base_data),
    .ex_flags_wen   (ex_flags_wen),
    .ex_flags       (ex_flags),
    .ex_ldm         (ex_ldm),
    .ex_reglist     (ex_reglist),
    .cspr_cur       (cspr_cur),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_rready     (mem_rready),
    .write_address  (write_address),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .write_address2 (write_address2),
    .write_data2    (write_data2),
    .write_enable2  (write_enable2),
    .pc_update      (pc_update),
    .pc_write       (pc_write),
    .cspr_update    (cspr_update),
    .cspr_write     (cspr_write),
    .busy           (busy)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid      (byp_valid),
    .byp_addr       (byp_addr),
    .byp_data       (byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkStrobes(input string tag, input exp_t e);
    checkOutput({tag, ".we1"}, 32'(write_enable), 32'(e.we1));
    if (e.we1) begin
      checkOutput({tag, ".a1"}, 32'(write_address), 32'(e.a1));
      checkOutput({tag, ".d1"}, write_data, e.d1);
    end
    checkOutput({tag, ".we2"}, 32'(write_enable2), 32'(e.we2));
    if (e.we2) begin
      checkOutput({tag, ".a2"}, 32'(write_address2), 32'(e.a2));
      checkOutput({tag, ".d2"}, write_data2, e.d2);
    end
    checkOutput({tag, ".pcw"}, 32'(pc_write), 32'(e.pcw));
    if (e.pcw) checkOutput({tag, ".pcu"}, pc_update, e.pcu);
    checkOutput({tag, ".cw"}, 32'(cspr_write), 32'(e.cw));
    if (e.cw) checkOutput({tag, ".cu"}, cspr_update, e.cu);
  endtask

  function automatic op_t mkop(bit wen, logic [3:0] rd, logic [31:0] res, bit bwen,
                               logic [3:0] brd, logic [31:0] bdata, bit fwen,
                               logic [3:0] flags, logic [31:0] cspr);
    op_t o;
    o.wen = wen; o.rd = rd; o.result = res;
    o.base_wen = bwen; o.base_rd = brd; o.base_data = bdata;
    o.flags_wen = fwen; o.flags = flags; o.cspr = cspr;
    return o;
  endfunction

  function automatic exp_t mkexp(bit we1, logic [3:0] a1, logic [31:0] d1, bit we2,
                                 logic [3:0] a2, logic [31:0] d2, bit pcw,
                                 logic [31:0] pcu, bit cw, logic [31:0] cu);
    exp_t e;
    e.we1 = we1; e.a1 = a1; e.d1 = d1;
    e.we2 = we2; e.a2 = a2; e.d2 = d2;
    e.pcw = pcw; e.pcu = pcu; e.cw = cw; e.cu = cu;
    return e;
  endfunction

  // Reference: writes land where the instruction names them, R15 goes to the PC port,
  // and the result keeps any register it shares with the base.
  function automatic exp_t modelSingle(op_t o);
    exp_t e = '0;
    bit   base_ok = o.base_wen && !(o.wen && (o.rd == o.base_rd));
    if (o.wen) begin
      if (o.rd == 4'd15) begin e.pcw = 1'b1; e.pcu = o.result; end
      else begin e.we1 = 1'b1; e.a1 = o.rd; e.d1 = o.result; end
    end
    if (base_ok) begin
      if (o.base_rd == 4'd15) begin e.pcw = 1'b1; e.pcu = o.base_data; end
      else begin e.we2 = 1'b1; e.a2 = o.base_rd; e.d2 = o.base_data; end
    end
    if (o.flags_wen) begin
      e.cw = 1'b1;
      e.cu = {o.flags, o.cspr[27:0]};
    end
    return e;
  endfunction

  task automatic applyStimulus(input op_t o);
    ex_valid     = 1'b1;
    ex_ldm       = 1'b0;
    ex_reglist   = '0;
    ex_wen       = o.wen;
    ex_rd        = o.rd;
    ex_result    = o.result;
    ex_base_wen  = o.base_wen;
    ex_base_rd   = o.base_rd;
    ex_base_data = o.base_data;
    ex_flags_wen = o.flags_wen;
    ex_flags     = o.flags;
    cspr_cur     = o.cspr;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic runLdm(input string tag, input logic [3:0] brd, input logic [31:0] bdata,
                        input logic bwen, input logic [15:0] list,
                        input logic [31:0] data_q[$], input int stall_q[$]);
    int   regs[$];
    exp_t e;
    for (int r = 0; r < 16; r++) if (list[r]) regs.push_back(r);

    checkOutput({tag, ".ready_in"}, 32'(ex_ready), 32'd1);
    ex_valid     = 1'b1;
    ex_ldm       = 1'b1;
    ex_reglist   = list;
    ex_base_wen  = bwen;
    ex_base_rd   = brd;
    ex_base_data = bdata;
    ex_wen       = 1'($urandom_range(0, 1));
    ex_rd        = 4'($urandom);
    ex_result    = $urandom;
    ex_flags_wen = 1'b1;
    ex_flags     = 4'($urandom);
    mem_rvalid   = 1'b0;
    tick();
    ex_valid = 1'b0;
    ex_ldm   = 1'b0;

    e = '0;
    if (bwen) begin
      if (brd == 4'd15) begin e.pcw = 1'b1; e.pcu = bdata; end
      else begin e.we2 = 1'b1; e.a2 = brd; e.d2 = bdata; end
    end
    checkStrobes({tag, ".base"}, e);
    checkOutput({tag, ".busy0"}, 32'(busy), 32'(regs.size() != 0));
    checkOutput({tag, ".ready0"}, 32'(ex_ready), 32'(regs.size() == 0));
    checkOutput({tag, ".rready0"}, 32'(mem_rready), 32'(regs.size() != 0));

    foreach (regs[k]) begin
      for (int s = 0; s < stall_q[k]; s++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        ex_valid   = 1'b1;
        ex_wen     = 1'b1;
        ex_rd      = 4'($urandom);
        ex_result  = $urandom;
        tick();
        ex_valid = 1'b0;
        checkStrobes({tag, ".stall"}, '0);
        checkOutput({tag, ".busy_stall"}, 32'(busy), 32'd1);
        checkOutput({tag, ".ready_stall"}, 32'(ex_ready), 32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = data_q[k];
      tick();
      mem_rvalid = 1'b0;
      e = '0;
      if (regs[k] == 15) begin e.pcw = 1'b1; e.pcu = data_q[k]; end
      else begin e.we1 = 1'b1; e.a1 = 4'(regs[k]); e.d1 = data_q[k]; end
      checkStrobes($sformatf("%s.beat%0d", tag, k), e);
      checkOutput({tag, ".busy_beat"}, 32'(busy), 32'(k != regs.size() - 1));
      checkOutput({tag, ".ready_beat"}, 32'(ex_ready), 32'(k == regs.size() - 1));
    end

    tick();
    checkStrobes({tag, ".after"}, '0);
    checkOutput({tag, ".rready_after"}, 32'(mem_rready), 32'd0);
  endtask

  initial begin
    vec_t        vecs[8];
    op_t         o;
    logic [31:0] dq[$];
    int          sq[$];
    logic [15:0] list;
    int          nbeats;

    rst_n = 1'b0; ex_valid = 1'b0; ex_wen = 1'b0; ex_rd = '0; ex_result = '0;
    ex_base_wen = 1'b0; ex_base_rd = '0; ex_base_data = '0; ex_flags_wen = 1'b0;
    ex_flags = '0; ex_ldm = 1'b0; ex_reglist = '0; cspr_cur = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    vecs[0] = '{"rd3_flags", mkop(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0, 1, 4'b1001, 32'h000000D3),
                mkexp(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h900000D3)};
    vecs[1] = '{"pc_route", mkop(1, 4'd15, 32'h100, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0),
                mkexp(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 32'h100, 0, 32'h0)};
    vecs[2] = '{"conflict5", mkop(1, 4'd5, 32'h11, 1, 4'd5, 32'h22, 0, 4'd0, 32'h0),
                mkexp(1, 4'd5, 32'h11, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0)};
    vecs[3] = '{"base_only", mkop(0, 4'd0, 32'h0, 1, 4'd7, 32'h1234, 0, 4'd0, 32'h0),
                mkexp(0, 4'd0, 32'h0, 1, 4'd7, 32'h1234, 0, 32'h0, 0, 32'h0)};
    vecs[4] = '{"base_pc", mkop(1, 4'd2, 32'h55, 1, 4'd15, 32'h400, 0, 4'd0, 32'h0),
                mkexp(1, 4'd2, 32'h55, 0, 4'd0, 32'h0, 1, 32'h400, 0, 32'h0)};
    vecs[5] = '{"both_pc", mkop(1, 4'd15, 32'hAAA, 1, 4'd15, 32'hBBB, 0, 4'd0, 32'h0),
                mkexp(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 32'hAAA, 0, 32'h0)};
    vecs[6] = '{"flags_only", mkop(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'b0110, 32'hF00000FF),
                mkexp(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'h600000FF)};
    vecs[7] = '{"no_writes", mkop(0, 4'd9, 32'h77, 0, 4'd9, 32'h88, 0, 4'd0, 32'h0),
                mkexp(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0)};

    #3;
    checkStrobes("reset", '0);
    checkOutput("reset.addr1", 32'(write_address), 32'd0);
    checkOutput("reset.data2", write_data2, 32'd0);
    checkOutput("reset.ready", 32'(ex_ready), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.rready", 32'(mem_rready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset.ready", 32'(ex_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op);
      checkStrobes(vecs[i].name, vecs[i].exp);
      tick();
      checkStrobes({vecs[i].name, ".pulse"}, '0);
    end

    dq = '{32'hA, 32'hB, 32'hC};
    sq = '{0, 2, 0};
    runLdm("ldm_plan", 4'd1, 32'h2000, 1'b1, 16'h8006, dq, sq);

    dq = {};
    sq = {};
    runLdm("ldm_empty", 4'd4, 32'h3000, 1'b1, 16'h0000, dq, sq);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        list = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
        dq = {};
        sq = {};
        nbeats = $countones(list);
        for (int b = 0; b < nbeats; b++) begin
          dq.push_back($urandom);
          sq.push_back($urandom_range(0, 2));
        end
        runLdm($sformatf("rnd_ldm%0d", it), 4'($urandom), $urandom,
               1'($urandom_range(0, 1)), list, dq, sq);
      end else begin
        o = mkop(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom_range(0, 1)),
                 4'($urandom), $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        if ($urandom_range(0, 3) == 0) o.rd = 4'd15;
        if ($urandom_range(0, 2) == 0) o.base_rd = o.rd;
        applyStimulus(o);
        checkStrobes($sformatf("rnd_op%0d", it), modelSingle(o));
        tick();
        checkStrobes($sformatf("rnd_op%0d.pulse", it), '0);
      end
    end

    // Reset in the middle of an LDM: the visible strobe drops and the remaining beats vanish.
    ex_valid = 1'b1; ex_ldm = 1'b1; ex_reglist = 16'h00F0; ex_base_wen = 1'b0;
    ex_wen = 1'b0; ex_flags_wen = 1'b0; mem_rvalid = 1'b0;
    tick();
    ex_valid = 1'b0; ex_ldm = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h4444;
    tick();
    checkStrobes("rst_mid.beat", mkexp(1, 4'd4, 32'h4444, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'h0));
    #2;
    rst_n = 1'b0;
    #1;
    checkStrobes("rst_mid.drop", '0);
    checkOutput("rst_mid.ready", 32'(ex_ready), 32'd0);
    checkOutput("rst_mid.busy", 32'(busy), 32'd0);
    checkOutput("rst_mid.rready", 32'(mem_rready), 32'd0);
    tick();
    checkOutput("rst_mid.ready_held", 32'(ex_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_mid.ready_rel", 32'(ex_ready), 32'd1);
    tick();
    checkStrobes("rst_mid.abandon", '0);
    checkOutput("rst_mid.busy_rel", 32'(busy), 32'd0);
    mem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
